// File: rtl/pipelined_addsub_if.sv
// Handshake and operand/result bundle for pipelined_addsub.
// master drives operands and out_ready; slave is the adder side.
interface pipelined_addsub_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, A, B, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, A, B, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub: one WIDTH/STAGES-bit slice per stage, carry registered.
// Flag outputs are live only when ADDSUB_FLAGS_EN is defined; otherwise they are tied to 0.
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input logic              clk,
  input logic              reset,
  pipelined_addsub_if.slave bus
);
  localparam int unsigned S = WIDTH / STAGES;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_in;
    logic             c_in;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [S:0]       slice;
    logic [WIDTH-1:0] s_next;
    logic             load;
    logic             valid_q;
    logic             c_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] s_q;
    logic             unused_q;

    if (k == 0) begin : g_head
      assign v_in = bus.in_valid;
      assign a_in = bus.A;
      assign b_in = bus.B ^ {WIDTH{bus.sub}};
      assign c_in = bus.sub;
      assign s_in = '0;
    end else begin : g_body
      assign v_in = g_stage[k-1].valid_q;
      assign a_in = g_stage[k-1].a_q;
      assign b_in = g_stage[k-1].b_q;
      assign c_in = g_stage[k-1].c_q;
      assign s_in = g_stage[k-1].s_q;
    end

    // A stage may load when empty or when its successor is draining it.
    if (k == STAGES - 1) begin : g_tail
      assign load = !valid_q || bus.out_ready;
    end else begin : g_link
      assign load = !valid_q || g_stage[k+1].load;
    end

    assign slice = {1'b0, a_in[k*S +: S]} + {1'b0, b_in[k*S +: S]} + {{S{1'b0}}, c_in};

    always_comb begin
      s_next            = s_in;
      s_next[k*S +: S]  = slice[S-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        valid_q <= 1'b0;
        c_q     <= 1'b0;
        a_q     <= '0;
        b_q     <= '0;
        s_q     <= '0;
      end else if (load) begin
        valid_q <= v_in;
        if (v_in) begin
          a_q <= a_in;
          b_q <= b_in;
          s_q <= s_next;
          c_q <= slice[S];
        end
      end
    end

    // Consumed operand slices and the final carry are dead past this stage.
    assign unused_q = ^{a_q, b_q, c_q};
  end

  assign bus.in_ready  = g_stage[0].load;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.sum       = g_stage[STAGES-1].s_q;

`ifdef ADDSUB_FLAGS_EN
  logic cout_q;
  logic ovf_q;
  logic zero_q;
  logic neg_q;
  logic msb_cin;

  // Carry into the MSB recovered from the MSB's own sum bit.
  assign msb_cin = g_stage[STAGES-1].a_in[WIDTH-1] ^ g_stage[STAGES-1].b_in[WIDTH-1] ^
                   g_stage[STAGES-1].s_next[WIDTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (g_stage[STAGES-1].load && g_stage[STAGES-1].v_in) begin
      cout_q <= g_stage[STAGES-1].slice[S];
      ovf_q  <= msb_cin ^ g_stage[STAGES-1].slice[S];
      zero_q <= (g_stage[STAGES-1].s_next == '0);
      neg_q  <= g_stage[STAGES-1].s_next[WIDTH-1];
    end
  end

  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign bus.negative = neg_q;
`else
  assign bus.cout     = 1'b0;
  assign bus.overflow = 1'b0;
  assign bus.zero     = 1'b0;
  assign bus.negative = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: one 64/4 instance for directed tests, three 8-bit instances for random sweep.
module tb_pipelined_addsub;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   pop1 = 0;
  int   pop2 = 0;
  int   pop8 = 0;

  logic [67:0] q64[$];
  logic [67:0] q1[$];
  logic [67:0] q2[$];
  logic [67:0] q8[$];

  always #5 clk = ~clk;

  pipelined_addsub_if #(.WIDTH(64)) m_if ();
  pipelined_addsub_if #(.WIDTH(8))  i1 ();
  pipelined_addsub_if #(.WIDTH(8))  i2 ();
  pipelined_addsub_if #(.WIDTH(8))  i8 ();

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) dut_m (.clk(clk), .reset(reset), .bus(m_if));
  pipelined_addsub #(.WIDTH(8),  .STAGES(1)) dut_1 (.clk(clk), .reset(reset), .bus(i1));
  pipelined_addsub #(.WIDTH(8),  .STAGES(2)) dut_2 (.clk(clk), .reset(reset), .bus(i2));
  pipelined_addsub #(.WIDTH(8),  .STAGES(8)) dut_8 (.clk(clk), .reset(reset), .bus(i8));

  // Reference: {negative, zero, overflow, cout, sum} from plain integer arithmetic.
  function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic s);
    logic [63:0] mask, am, bm, r;
    logic [64:0] full;
    logic        c, v, z, n, sa, sb, sr;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    if (s) begin
      r = (am - bm) & mask;
      c = (am >= bm);
    end else begin
      full = {1'b0, am} + {1'b0, bm};
      r    = full[63:0] & mask;
      c    = (full > {1'b0, mask});
    end
    sa = am[w-1];
    sb = bm[w-1];
    sr = r[w-1];
    v  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    z  = (r == 64'd0);
    n  = sr;
`ifndef ADDSUB_FLAGS_EN
    c = 1'b0;
    v = 1'b0;
    z = 1'b0;
    n = 1'b0;
`endif
    return {n, z, v, c, r};
  endfunction

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic empty_check(input string tag, input int size, input logic [63:0] got);
    n_assert++;
    assert (size != 0) else begin
      n_fail++;
      $error("FAIL %s: got unexpected beat %h expected no beat", tag, got);
    end
  endtask

  // Push on accept, pop on emit; both sampled mid-cycle.
  always @(negedge clk) if (reset) begin
    if (m_if.in_valid && m_if.in_ready) q64.push_back(model(64, m_if.A, m_if.B, m_if.sub));
    if (i1.in_valid && i1.in_ready) q1.push_back(model(8, {56'd0, i1.A}, {56'd0, i1.B}, i1.sub));
    if (i2.in_valid && i2.in_ready) q2.push_back(model(8, {56'd0, i2.A}, {56'd0, i2.B}, i2.sub));
    if (i8.in_valid && i8.in_ready) q8.push_back(model(8, {56'd0, i8.A}, {56'd0, i8.B}, i8.sub));
  end

  always @(negedge clk) if (reset) begin
    if (m_if.out_valid && m_if.out_ready) begin
      empty_check("m64_extra", q64.size(), m_if.sum);
      if (q64.size() != 0)
        check("m64_beat", {m_if.negative, m_if.zero, m_if.overflow, m_if.cout, m_if.sum},
              q64.pop_front());
    end
    if (i1.out_valid && i1.out_ready) begin
      empty_check("s1_extra", q1.size(), {56'd0, i1.sum});
      if (q1.size() != 0) begin
        check("s1_beat", {i1.negative, i1.zero, i1.overflow, i1.cout, 56'd0, i1.sum},
              q1.pop_front());
        pop1++;
      end
    end
    if (i2.out_valid && i2.out_ready) begin
      empty_check("s2_extra", q2.size(), {56'd0, i2.sum});
      if (q2.size() != 0) begin
        check("s2_beat", {i2.negative, i2.zero, i2.overflow, i2.cout, 56'd0, i2.sum},
              q2.pop_front());
        pop2++;
      end
    end
    if (i8.out_valid && i8.out_ready) begin
      empty_check("s8_extra", q8.size(), {56'd0, i8.sum});
      if (q8.size() != 0) begin
        check("s8_beat", {i8.negative, i8.zero, i8.overflow, i8.cout, 56'd0, i8.sum},
              q8.pop_front());
        pop8++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] b, input logic s);
    m_if.in_valid = v;
    m_if.A        = a;
    m_if.B        = b;
    m_if.sub      = s;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic r);
    i1.in_valid = v; i1.A = a; i1.B = b; i1.sub = s; i1.out_ready = r;
    i2.in_valid = v; i2.A = a; i2.B = b; i2.sub = s; i2.out_ready = r;
    i8.in_valid = v; i8.A = a; i8.B = b; i8.sub = s; i8.out_ready = r;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q64.size() + q1.size() + q2.size() + q8.size()) != 0; i++) tick();
    check("drain", 68'(q64.size() + q1.size() + q2.size() + q8.size()), 68'd0);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] held;
  int          acc;

  initial begin
    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[2] = '{64'd2, 64'd4, 1'b1};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1};

    drive(1'b0, 64'd0, 64'd0, 1'b0);
    m_if.out_ready = 1'b0;
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    #2;
    check("reset_out", {m_if.negative, m_if.zero, m_if.overflow, m_if.cout, m_if.sum},
          68'd0);
    check("reset_valid", 68'(m_if.out_valid), 68'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("in_ready_after_reset", 68'(m_if.in_ready), 68'd1);
    m_if.out_ready = 1'b1;
    tick();

    // Basic add and exact latency.
    drive(1'b1, 64'd4, 64'd2, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) drive(1'b0, 64'd0, 64'd0, 1'b0);
      check("latency", 68'(m_if.out_valid), 68'(i == 4));
    end
    drain();

    // Cross-slice carry, wrap, subtract, signed overflow.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].s);
      tick();
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0);
    drain();

    // Ten back-to-back beats, no gaps after initial latency.
    for (int i = 0; i < 14; i++) begin
      if (i < 10) drive(1'b1, 64'(i), 64'(i), 1'b0);
      else drive(1'b0, 64'd0, 64'd0, 1'b0);
      #1;
      if (i >= 4) check("stream_valid", 68'(m_if.out_valid), 68'd1);
      @(posedge clk);
      #1;
    end
    check("stream_end", 68'(m_if.out_valid), 68'd0);
    drain();

    // Backpressure: four beats fill the pipe, then in_ready drops and sum holds.
    m_if.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 64'(100 + acc), 64'(acc), 1'b0);
      #1;
      check("bp_in_ready", 68'(m_if.in_ready), 68'(i < 4));
      if (i == 4) held = m_if.sum;
      if (i == 5) begin
        check("bp_hold_sum", 68'(m_if.sum), 68'(held));
        check("bp_hold_valid", 68'(m_if.out_valid), 68'd1);
      end
      if (m_if.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0);
    m_if.out_ready = 1'b1;
    drain();

    // Asynchronous reset with three beats in flight.
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(10 + i), 64'd1, 1'b0);
      tick();
    end
    drive(1'b0, 64'd0, 64'd0, 1'b0);
    tick();
    check("pre_reset_valid", 68'(m_if.out_valid), 68'd1);
    reset = 1'b0;
    #1;
    check("async_reset_valid", 68'(m_if.out_valid), 68'd0);
    check("async_reset_sum", 68'(m_if.sum), 68'd0);
    q64.delete();
    tick();
    tick();
    reset = 1'b1;
    m_if.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_reset_idle", 68'(m_if.out_valid), 68'd0);
    end
    drive(1'b1, 64'd5, 64'd3, 1'b0);
    tick();
    drive(1'b0, 64'd0, 64'd0, 1'b0);
    drain();

    // Random sweep on the 8-bit instances with random stalls.
    for (int c = 0; c < 8000 && (pop1 < 1000 || pop2 < 1000 || pop8 < 1000); c++) begin
      drive8(($urandom_range(0, 9) != 0), 8'($urandom), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 3) != 0));
      tick();
    end
    drive8(1'b0, 8'd0, 8'd0, 1'b0, 1'b1);
    drain();
    check("sweep_count", 68'((pop1 >= 1000) && (pop2 >= 1000) && (pop8 >= 1000)), 68'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the pipelined datapath; next generation of the team's 64-bit ripple adder.
- Operand width is split into STAGES equal slices. One slice is resolved per stage, with the carry registered between stages.
- Valid/ready handshake on both sides gives full throughput (one op per cycle) and backpressure stalls without loss.
- NZCV-style flags accompany each result.

Parameters:
- WIDTH, 64, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth and number of carry slices; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- sub  input  1  1 = A−B, 0 = A+B
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of MSB; for subtract, 1 = no borrow
- overflow  output  1  signed overflow
- zero  output  1  sum == 0
- negative  output  1  sum[WIDTH-1]

Behaviour:
- Reset (reset=0, async): all stage valid bits clear. out_valid=0; sum, cout, overflow, zero, negative=0. in_ready=1 once reset deasserts.
- Accept: a beat is taken when in_valid && in_ready. Emit: a beat is delivered when out_valid && out_ready.
- Subtract path: B is inverted (B ^ {WIDTH{sub}}) and sub is used as the carry-in to slice 0.
- Slice size is S = WIDTH/STAGES. Stage k (0-based) adds slice k of A and B′ plus the registered carry from stage k−1. Stage 0 uses sub as its carry-in.
- Operand bits for later slices travel with the beat. Completed low slices also travel with the beat.
- Latency: exactly STAGES cycles from accept to out_valid when there is no backpressure.
- Stage register k loads when its valid is 0 or stage k+1 is loading. The last stage loads when out_valid=0 or out_ready=1.
- in_ready = (stage 0 empty) OR (stage 0 advancing). in_ready is combinational from out_ready through the chain; this is permitted.
- Simultaneous accept and emit with the pipe full: both occur and occupancy is unchanged.
- Bubbles: an empty stage never blocks. Invalid beats are compressed out under backpressure.
- Output data is held stable while out_valid=1 and out_ready=0.
- Flag definitions:
  - cout = carry out of bit WIDTH−1.
  - overflow = carry into MSB XOR carry out of MSB.
  - zero and negative are computed from the final sum.
- Wrap-around: results are modulo 2^WIDTH with no saturation.
- Reset mid-operation: all in-flight beats are discarded. No output beat is produced after reset deasserts until a new beat is accepted.
- Edge case STAGES=1: single register, latency 1.

Optional Feature:
- Macro: ADDSUB_FLAGS_EN.
- Defined: cout, overflow, zero and negative behave as above. Per-stage carry and flag state is registered.
- Undefined: the flag ports remain present but are tied to 0. No flag logic or flag registers are synthesised. sum and the handshake are unchanged.

Test Plan:
- Basic add, WIDTH=64, STAGES=4: A=4, B=2, sub=0 → exactly 4 cycles later out_valid=1, sum=6, cout=0, overflow=0, zero=0, negative=0.
- Cross-slice carry, with ADDSUB_FLAGS_EN: A=64'h0000_0000_FFFF_FFFF, B=1 → sum=64'h0000_0001_0000_0000. Then A=64'hFFFF_FFFF_FFFF_FFFF, B=1 → sum=0, cout=1, zero=1.
- Subtract and signed overflow:
  - A=2, B=4, sub=1 → sum=64'hFFFF_FFFF_FFFF_FFFE, cout=0, negative=1.
  - A=64'h7FFF_FFFF_FFFF_FFFF, B=1, sub=0 → overflow=1, negative=1.
  - A=64'h8000_0000_0000_0000, B=1, sub=1 → overflow=1.
- Throughput and backpressure:
  - Stream 10 back-to-back beats (A=i, B=i) with out_ready=1 → 10 consecutive results 2i, no gaps after the initial latency.
  - Then hold out_ready=0 for 6 cycles → in_ready drops after 4 beats are queued, sum stays stable, no beat is lost or duplicated.
- Reset mid-stream: assert reset with 3 beats in flight → out_valid=0 immediately (asynchronous). After deassert with no new input, no output for 10 cycles. The next beat A=5, B=3 → sum=8.
- Parameter sweep: WIDTH=8 with STAGES=1, 2, 8; random A/B/sub vs. a reference model → sum and flags match for 1000 beats each. With ADDSUB_FLAGS_EN undefined → flags always 0.
